game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
Round controller that sits directly upstream of game_timer.
- Debounces the two player buttons and sequences each round: clear timer, run timer, count hits, freeze on timer done.
- Drives game_timer's en and rst inputs, consumes its done output, and presents the round score to the display path.

Parameters:
DB_CYCLES, 1000000, stable-input cycles required before a debounced button changes state (10 ms at 100 MHz); minimum 2.
SCORE_W, 8, score counter width in bits.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous, active-high reset.
btn_start  input  1  raw asynchronous start button, active-high.
btn_hit  input  1  raw asynchronous hit button, active-high.
timer_done  input  1  done level from game_timer.
timer_en  output  1  count enable to game_timer.
timer_clr  output  1  one-cycle clear pulse to game_timer rst.
score  output  SCORE_W  hits registered in the current/last round.
hi_score  output  SCORE_W  best score since reset (see Optional Feature).
state_o  output  2  encoded FSM state: 0 IDLE, 1 ARM, 2 RUN, 3 OVER.

Behaviour:
Reset:
- rst is sampled on the clk rising edge only; rst=1 overrides every other input.
- Reset values: state IDLE, timer_en=0, timer_clr=0, score=0, hi_score=0, synchronizers and debounce counters 0.

Input conditioning (per button):
- Two-flop synchronizer, then a counter debounce of width $clog2(DB_CYCLES).
- The debounced level changes only after the synced input differs from it for DB_CYCLES consecutive cycles; any agreeing sample resets the counter.
- A press pulse is a one-cycle pulse on the debounced 0->1 transition.
- Raw-input-to-pulse latency = DB_CYCLES+3 cycles. Releases generate no pulse.

FSM (all outputs registered):
- IDLE: timer_en=0. start press -> ARM.
- ARM: lasts exactly 1 cycle.
  - timer_clr=1, score cleared to 0.
  - Next state RUN unconditionally.
- RUN: timer_en=1.
  - Each hit press increments score by 1.
  - Score saturates at 2^SCORE_W-1, with no wrap.
  - timer_done=1 -> OVER.
  - Start presses are ignored in RUN.
- OVER: timer_en=0, score frozen.
  - On the entry cycle, hi_score <= score if score > hi_score.
  - start press -> ARM. Hit presses are ignored.

Boundary and ordering rules:
- Hit press and timer_done in the same RUN cycle: the hit is counted, then the FSM goes to OVER.
- The hi_score comparison uses the post-increment value.
- timer_done asserted outside RUN is ignored. timer_done still high in the cycle after ARM (stale level) is ignored: RUN masks timer_done for its first cycle.
- Start and hit pressed in the same cycle in IDLE/OVER: start wins and the hit is dropped.
- rst asserted mid-RUN: next cycle is IDLE with timer_en=0 and score=0.
- A held button produces exactly one press pulse.

Optional Feature:
Macro GAME_CTRL_HISCORE_EN.
- Defined: hi_score register and compare logic are present, as described above.
- Undefined: no hi_score register exists; hi_score is tied to 0; the OVER entry does not compare.

Test Plan:
All scenarios use DB_CYCLES=4, SCORE_W=4.
1. Reset: hold rst 3 cycles with both buttons high -> state_o=0, timer_en=0, timer_clr=0, score=0, hi_score=0.
2. Debounce: glitch btn_start high for 3 cycles, then low -> no transition. Hold it high for 10 cycles -> exactly one ARM cycle with timer_clr=1, then state_o=2, timer_en=1.
3. Scoring: in RUN, 5 separated hit presses, then timer_done=1 -> score=5, state_o=3, timer_en=0, hi_score=5. Further hit presses leave score at 5.
4. Second round: start from OVER, 3 hits, then done -> score=3, hi_score stays 5.
5. Saturation and simultaneity: 16 hits in RUN -> score=15. A hit coinciding with timer_done -> counted. Stale timer_done=1 during ARM -> FSM still enters and holds RUN.
6. Mid-round reset: rst pulse in RUN with score=7 -> next cycle state_o=0, score=0, timer_en=0. With GAME_CTRL_HISCORE_EN undefined -> hi_score=0 throughout scenario 3.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl - round controller sitting directly upstream of game_timer.
//
// Debounces the start and hit buttons and sequences each round:
// clear the timer, run it, count hits, and freeze when the timer reports done.
//
// Optional feature macro: GAME_CTRL_HISCORE_EN
//   defined   -> a best-score register tracks the highest round score since reset
//   undefined -> no best-score register; hi_score is tied to 0
//
// Parameters:
//   DB_CYCLES  stable-input cycles before a debounced button changes (>= 2)
//   SCORE_W    score counter width in bits
//
// Ports:
//   clk         system clock, single domain
//   rst         synchronous active-high reset
//   btn_start   raw asynchronous start button, active-high
//   btn_hit     raw asynchronous hit button, active-high
//   timer_done  done level from game_timer
//   timer_en    count enable to game_timer (high while in RUN)
//   timer_clr   one-cycle clear pulse to game_timer rst (high while in ARM)
//   score       hits registered in the current/last round
//   hi_score    best score since reset (0 when the feature is disabled)
//   state_o     encoded FSM state: 0 IDLE, 1 ARM, 2 RUN, 3 OVER
module game_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_hit,
  input  logic               timer_done,
  output logic               timer_en,
  output logic               timer_clr,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic [1:0]         state_o
);

  localparam int                CW        = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    OVER = 2'd3
  } state_t;

  // Bit 0 carries the start button, bit 1 the hit button.
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    db_r;
  logic [1:0]    db_d_r;
  logic [1:0]    press_r;
  logic [CW-1:0] cnt_r [2];

  state_t               state_r;
  state_t               state_nxt_s;
  logic [SCORE_W-1:0]   score_r;
  logic [SCORE_W-1:0]   score_nxt_s;
  logic                 timer_en_r;
  logic                 timer_clr_r;
  logic                 run_first_r;
  logic                 start_p_s;
  logic                 hit_p_s;

  assign start_p_s = press_r[0];
  assign hit_p_s   = press_r[1];

  // Synchronize, debounce and edge-detect both buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      db_r    <= 2'b00;
      db_d_r  <= 2'b00;
      press_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_r <= {btn_hit, btn_start};
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      // Registered rising edge of the debounced level: one pulse per press.
      press_r <= db_r & ~db_d_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          cnt_r[i] <= {CW{1'b0}};
        end else if (cnt_r[i] == CNT_LAST) begin
          // This is the DB_CYCLES-th consecutive disagreeing sample.
          cnt_r[i] <= {CW{1'b0}};
          db_r[i]  <= sync2_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Next-state and next-score logic.
  always_comb begin
    state_nxt_s = state_r;
    score_nxt_s = score_r;
    case (state_r)
      IDLE: begin
        // Start wins over a coincident hit; hits are never counted here.
        if (start_p_s) begin
          state_nxt_s = ARM;
          score_nxt_s = {SCORE_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARM: begin
        state_nxt_s = RUN;
        score_nxt_s = {SCORE_W{1'b0}};
      end
      RUN: begin
        if (hit_p_s && (score_r != SCORE_MAX)) begin
          score_nxt_s = score_r + SCORE_W'(1);
        end else begin
          score_nxt_s = score_r;
        end
        // A done level left over from the previous round is ignored on the
        // first RUN cycle; the timer was only just cleared.
        if (timer_done && !run_first_r) begin
          state_nxt_s = OVER;
        end else begin
          state_nxt_s = RUN;
        end
      end
      OVER: begin
        if (start_p_s) begin
          state_nxt_s = ARM;
          score_nxt_s = {SCORE_W{1'b0}};
        end else begin
          state_nxt_s = OVER;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        score_nxt_s = {SCORE_W{1'b0}};
      end
    endcase
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      score_r     <= {SCORE_W{1'b0}};
      timer_en_r  <= 1'b0;
      timer_clr_r <= 1'b0;
      run_first_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      score_r     <= score_nxt_s;
      timer_en_r  <= (state_nxt_s == RUN);
      timer_clr_r <= (state_nxt_s == ARM);
      run_first_r <= (state_nxt_s == RUN) && (state_r == ARM);
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] hi_r;

  // Best-score update on OVER entry, using the post-increment score.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= {SCORE_W{1'b0}};
    end else if ((state_r == RUN) && (state_nxt_s == OVER) && (score_nxt_s > hi_r)) begin
      hi_r <= score_nxt_s;
    end else begin
      hi_r <= hi_r;
    end
  end

  assign hi_score = hi_r;
`else
  assign hi_score = {SCORE_W{1'b0}};
`endif

  assign timer_en  = timer_en_r;
  assign timer_clr = timer_clr_r;
  assign score     = score_r;
  assign state_o   = state_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with DB_CYCLES=4, SCORE_W=4.
// Expected output snapshots are queued when stimulus is applied and
// compared against the DUT once the outputs have settled.
module tb_game_ctrl;

  localparam int DB = 4;
  localparam int SW = 4;
`ifdef GAME_CTRL_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  logic          clk;
  logic          rst;
  logic          btn_start;
  logic          btn_hit;
  logic          timer_done;
  logic          timer_en;
  logic          timer_clr;
  logic [SW-1:0] score;
  logic [SW-1:0] hi_score;
  logic [1:0]    state_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string         tag;
    logic [1:0]    st;
    logic          en;
    logic          clr;
    logic [SW-1:0] sc;
    logic [SW-1:0] hi;
  } exp_t;

  exp_t sb[$];

  game_ctrl #(.DB_CYCLES(DB), .SCORE_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_hit    (btn_hit),
    .timer_done (timer_done),
    .timer_en   (timer_en),
    .timer_clr  (timer_clr),
    .score      (score),
    .hi_score   (hi_score),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] hexp(input int v);
    return HI_EN ? SW'(v) : {SW{1'b0}};
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [1:0] st, input logic en,
                         input logic clr, input logic [SW-1:0] sc, input logic [SW-1:0] hi);
    exp_t e;
    e.tag = tag; e.st = st; e.en = en; e.clr = clr; e.sc = sc; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".state"}, 8'(state_o),   8'(e.st));
      cmp({e.tag, ".en"},    8'(timer_en),  8'(e.en));
      cmp({e.tag, ".clr"},   8'(timer_clr), 8'(e.clr));
      cmp({e.tag, ".score"}, 8'(score),     8'(e.sc));
      cmp({e.tag, ".hi"},    8'(hi_score),  8'(e.hi));
    end
  endtask

  // One separated hit press: hold past the debounce, then release fully.
  task automatic press_hit();
    btn_hit = 1'b1;
    tick(8);
    btn_hit = 1'b0;
    tick(8);
  endtask

  initial begin
    rst        = 1'b1;
    btn_start  = 1'b1;
    btn_hit    = 1'b1;
    timer_done = 1'b0;

    // 1. Reset with both buttons held high.
    sb_push("reset", S_IDLE, 1'b0, 1'b0, 4'd0, 4'd0);
    tick(3);
    sb_check();
    rst = 1'b0; btn_start = 1'b0; btn_hit = 1'b0;
    sb_push("post_reset", S_IDLE, 1'b0, 1'b0, 4'd0, 4'd0);
    tick(10);
    sb_check();

    // 2. Debounce: a 3-cycle glitch is rejected.
    btn_start = 1'b1;
    tick(3);
    btn_start = 1'b0;
    sb_push("glitch", S_IDLE, 1'b0, 1'b0, 4'd0, 4'd0);
    tick(12);
    sb_check();

    // Held press: pulse after DB+3 cycles, FSM in ARM one edge later.
    btn_start = 1'b1;
    sb_push("pre_arm", S_IDLE, 1'b0, 1'b0, 4'd0, 4'd0);
    tick(7);
    sb_check();
    sb_push("arm", S_ARM, 1'b0, 1'b1, 4'd0, 4'd0);
    tick(1);
    sb_check();
    sb_push("run1", S_RUN, 1'b1, 1'b0, 4'd0, 4'd0);
    tick(1);
    sb_check();
    tick(1);
    btn_start = 1'b0;
    sb_push("held_once", S_RUN, 1'b1, 1'b0, 4'd0, 4'd0);
    tick(10);
    sb_check();

    // 3. Five hits then done.
    sb_push("hits5", S_RUN, 1'b1, 1'b0, 4'd5, 4'd0);
    for (int i = 0; i < 5; i++) press_hit();
    sb_check();
    timer_done = 1'b1;
    sb_push("over5", S_OVER, 1'b0, 1'b0, 4'd5, hexp(5));
    tick(1);
    timer_done = 1'b0;
    sb_check();
    sb_push("over_hits", S_OVER, 1'b0, 1'b0, 4'd5, hexp(5));
    press_hit();
    press_hit();
    sb_check();

    // 4. Second round: two hits, then a hit coinciding with done.
    btn_start = 1'b1;
    sb_push("arm2", S_ARM, 1'b0, 1'b1, 4'd0, hexp(5));
    tick(8);
    sb_check();
    btn_start = 1'b0;
    tick(8);
    press_hit();
    press_hit();
    sb_push("hits2", S_RUN, 1'b1, 1'b0, 4'd2, hexp(5));
    sb_check();
    btn_hit = 1'b1;
    tick(7);
    timer_done = 1'b1;
    sb_push("hit_and_done", S_OVER, 1'b0, 1'b0, 4'd3, hexp(5));
    tick(1);
    timer_done = 1'b0;
    btn_hit = 1'b0;
    sb_check();
    tick(8);

    // 5. Stale done across ARM, then saturation.
    timer_done = 1'b1;
    btn_start  = 1'b1;
    sb_push("done_in_over", S_OVER, 1'b0, 1'b0, 4'd3, hexp(5));
    tick(7);
    sb_check();
    sb_push("arm3", S_ARM, 1'b0, 1'b1, 4'd0, hexp(5));
    tick(1);
    sb_check();
    sb_push("run_stale", S_RUN, 1'b1, 1'b0, 4'd0, hexp(5));
    tick(1);
    sb_check();
    sb_push("run_masked", S_RUN, 1'b1, 1'b0, 4'd0, hexp(5));
    tick(1);
    sb_check();
    timer_done = 1'b0;
    btn_start  = 1'b0;
    sb_push("run_hold", S_RUN, 1'b1, 1'b0, 4'd0, hexp(5));
    tick(8);
    sb_check();
    sb_push("saturate", S_RUN, 1'b1, 1'b0, 4'd15, hexp(5));
    for (int i = 0; i < 16; i++) press_hit();
    sb_check();
    timer_done = 1'b1;
    sb_push("over15", S_OVER, 1'b0, 1'b0, 4'd15, hexp(15));
    tick(1);
    timer_done = 1'b0;
    sb_check();

    // 6. Mid-round reset with score 7.
    btn_start = 1'b1;
    tick(8);
    btn_start = 1'b0;
    tick(8);
    sb_push("hits7", S_RUN, 1'b1, 1'b0, 4'd7, hexp(15));
    for (int i = 0; i < 7; i++) press_hit();
    sb_check();
    rst = 1'b1;
    sb_push("mid_reset", S_IDLE, 1'b0, 1'b0, 4'd0, 4'd0);
    tick(1);
    rst = 1'b0;
    sb_check();
    sb_push("after_reset", S_IDLE, 1'b0, 1'b0, 4'd0, 4'd0);
    tick(3);
    sb_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
